// File: rtl/fetch_pkg.sv
// Shared fetch definitions: datapath widths, default reset PC, NOP encoding and
// the {pc, instr} record carried through the prefetch queue.
package fetch_pkg;

  localparam int unsigned InstrW = 32;
  localparam int unsigned PcW    = 32;

  localparam logic [PcW-1:0]    ResetPcDefault = 32'h0000_0000;
  localparam logic [InstrW-1:0] NopInstr       = 32'h0000_0013;

  typedef logic [PcW-1:0]    pc_t;
  typedef logic [InstrW-1:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

  // PC counts words; wraps from all-ones back to zero.
  function automatic pc_t pc_next(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch buffer of QDEPTH {pc, instr} entries with push, pop and flush.
// Caller guarantees no pop when empty and no push when full unless popping too.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned PtrW  = $clog2(QDEPTH),
  localparam int unsigned CntW  = $clog2(QDEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  fetch_entry_t       push_entry_i,
  input  logic               pop_i,
  output fetch_entry_t       head_o,
  output logic [CntW-1:0]    count_o
);

  fetch_entry_t    mem_q [QDEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction-memory read and a prefetch
// queue feeding decode. Redirects flush the queue and restart at the target.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned    QDEPTH   = 2,
  parameter logic [PcW-1:0] RESET_PC = ResetPcDefault
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PcW-1:0]    imem_addr,
  output logic              imem_re,
  input  logic [InstrW-1:0] imem_out,
  input  logic              redirect_valid,
  input  logic [PcW-1:0]    redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [InstrW-1:0] dec_instr,
  output logic [PcW-1:0]    dec_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned     CntW   = $clog2(QDEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(QDEPTH);

  pc_t             pc_q, pc_d;
  logic            fetch;
  logic            pop;
  logic [CntW-1:0] count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  assign dec_valid = (count != '0);
  // A redirect discards the queue, so a concurrent handshake is not a pop.
  assign pop       = dec_valid && dec_ready && !redirect_valid;
  // Gate with rst so no read is issued while reset is held.
  assign fetch     = !rst && !redirect_valid && ((count < DepthC) || pop);

  assign push_entry = '{pc: pc_q, instr: imem_out};

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (redirect_valid),
    .push_i       (fetch),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count)
  );

  // PC next-state: redirect target, sequential advance on fetch, else hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (fetch) begin
      pc_d = pc_next(pc_q);
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign imem_addr = pc_q;
  assign imem_re   = fetch;
  assign dec_pc    = head.pc;
  assign dec_instr = head.instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counter next-state; both wrap naturally at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch)                   fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (dec_valid && !dec_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter QDEPTH, default 2, meaning prefetch queue depth in entries (power of two, >=2).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0, meaning the word index fetched first after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  32  word index into instruction memory, always equal to the PC register.
REQ-006 SHALL have port imem_re  output  1  read enable to instruction memory.
REQ-007 SHALL have port imem_out  input  32  instruction word, combinationally valid in the same cycle as imem_addr/imem_re.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  32  target word index for redirect.
REQ-010 SHALL have port dec_valid  output  1  head queue entry is valid for decode.
REQ-011 SHALL have port dec_ready  input  1  decode accepts head entry this cycle.
REQ-012 SHALL have port dec_instr  output  32  head instruction word.
REQ-013 SHALL have port dec_pc  output  32  word index of head instruction.

Function
REQ-014 PC SHALL be a word index; sequential increment is +1, wrapping 32'hFFFFFFFF -> 0.
REQ-015 Pop SHALL occur when dec_valid && dec_ready; dec_valid SHALL equal (count != 0).
REQ-016 Fetch SHALL occur when !redirect_valid && (count < QDEPTH || pop): imem_re=1, push {PC, imem_out} at the clock edge, PC <= PC+1.
REQ-017 When not fetching, imem_re SHALL be 0 and PC SHALL hold.
REQ-018 Simultaneous push and pop on a full queue SHALL keep count at QDEPTH with no entry lost or duplicated.
REQ-019 Latency: an instruction fetched in cycle N SHALL appear on dec_instr/dec_pc in cycle N+1 (no same-cycle bypass).
REQ-020 On redirect_valid: queue SHALL flush (count <= 0), PC <= redirect_pc, no push, imem_re=0, and any concurrent pop SHALL be ignored.
REQ-021 After a redirect in cycle R, the target instruction SHALL be fetched in R+1 and presented with dec_valid=1 in R+2.
REQ-022 When the queue is empty, dec_instr and dec_pc SHALL read 32'h0.
REQ-023 Entries SHALL be presented in strict fetch order; dec_instr/dec_pc SHALL be stable while dec_valid && !dec_ready.

Reset
REQ-024 On rst assertion (any time, including mid-stream or mid-redirect) PC SHALL become RESET_PC, queue count and pointers 0, dec_valid 0, imem_re 0 while rst is high.
REQ-025 The first fetch SHALL occur in the first cycle after rst deasserts, with dec_valid=1 one cycle later.

Configuration
REQ-026 Macro FETCH_PERF_CNT_EN defined SHALL add outputs perf_fetch_cnt (32) counting fetch cycles and perf_stall_cnt (32) counting cycles with dec_valid && !dec_ready, both reset to 0, wrapping at 2^32.
REQ-027 Without FETCH_PERF_CNT_EN these ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package fetch_pkg SHALL hold the instruction width (32), PC width (32), RESET_PC default and the NOP encoding 32'h00000013.
REQ-029 The queue SHALL be a separate sub-module fetch_queue (circular buffer, QDEPTH entries of {pc, instr}, push/pop/flush, count).

Verification
REQ-030 Reset release, dec_ready=1, memory words 0..3 loaded -> dec_pc 0,1,2,3 on consecutive cycles starting cycle 1, one instruction per cycle.
REQ-031 dec_ready=0 for 5 cycles after reset -> imem_re drops after 2 fetches (QDEPTH=2), PC=2, dec_pc holds 0; dec_ready=1 -> order 0,1,2 resumes with no gap.
REQ-032 redirect_valid with redirect_pc=21 while queue holds PCs 5,6 -> next cycle dec_valid=0, fetch at 21, following cycle dec_pc=21, dec_instr=memory[21].
REQ-033 rst asserted mid-stream with queue full -> dec_valid=0 immediately (asynchronous), after release first dec_pc=RESET_PC.
REQ-034 redirect_pc=32'hFFFFFFFF -> dec_pc sequence FFFFFFFF then 00000000.
REQ-035 With FETCH_PERF_CNT_EN, 10 fetches and 3 back-pressured cycles -> perf_fetch_cnt=10, perf_stall_cnt=3.
